// File: rtl/regfile_pkg.sv
// ============================================================================
// Package  : regfile_pkg
// Brief    : Shared types and default dimensions for the multiport register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int RF_DATA_WIDTH = 16;
    localparam int RF_ADDR_WIDTH = 6;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_multiport_if.sv
// ============================================================================
// Interface : regfile_multiport_if
// Brief     : Write port, packed read ports and status of the register file.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_multiport_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_READ   = 2
);

    logic                           WriteEnable;
    logic [ADDR_WIDTH-1:0]          WriteAddress;
    logic [DATA_WIDTH-1:0]          WriteData;
    logic [NUM_READ*ADDR_WIDTH-1:0] ReadAddress;
    logic [NUM_READ*DATA_WIDTH-1:0] ReadData;
    logic                           Ready;
    logic                           WriteDropped;

    modport master (
        output WriteEnable, WriteAddress, WriteData, ReadAddress,
        input  ReadData, Ready, WriteDropped
    );

    modport slave (
        input  WriteEnable, WriteAddress, WriteData, ReadAddress,
        output ReadData, Ready, WriteDropped
    );

endinterface : regfile_multiport_if

`default_nettype wire

// File: rtl/regfile_clear_fsm.sv
// ============================================================================
// Module   : regfile_clear_fsm
// Brief    : Post-reset sweep that zeroes every register, then holds Ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  wire logic                  Clock,
    input  wire logic                  Reset,
    output logic                       ClearWrite,
    output logic [ADDR_WIDTH:0]        ClearIndex,
    output logic                       Ready
);

    localparam int                 c_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_LAST  = (ADDR_WIDTH + 1)'(c_DEPTH - 1);

    rf_state_t           r_state;
    rf_state_t           w_nextState;
    logic [ADDR_WIDTH:0] r_clearIndex;
    logic [ADDR_WIDTH:0] w_nextIndex;
    logic                r_ready;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= CLEAR;
            r_clearIndex <= '0;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_clearIndex <= w_nextIndex;
            r_ready      <= (w_nextState == READY);
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextIndex = r_clearIndex;
        ClearWrite  = 1'b0;
        case (r_state)
            CLEAR: begin
                // Reset held high must leave storage untouched.
                ClearWrite  = !Reset;
                w_nextIndex = r_clearIndex + 1'b1;
                if (r_clearIndex == c_LAST) begin
                    w_nextState = READY;
                end
            end
            READY: begin
                w_nextState = READY;
            end
            default: begin
                w_nextState = CLEAR;
            end
        endcase
    end

    assign ClearIndex = r_clearIndex;
    assign Ready      = r_ready;

endmodule : regfile_clear_fsm

`default_nettype wire

// File: rtl/regfile_multiport.sv
// ============================================================================
// Module   : regfile_multiport
// Brief    : 1W / NUM_READ-R register file with bypass, zero register, clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  wire logic           Clock,
    input  wire logic           Reset,
    regfile_multiport_if.slave  bus
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_registers [c_DEPTH];
    logic                  w_clearWrite;
    logic [ADDR_WIDTH:0]   w_clearIndex;
    logic                  w_ready;
    logic                  w_zeroHit;
    logic                  w_writeAccept;
    logic                  r_writeDropped;

    regfile_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_fsm (
        .Clock      (Clock),
        .Reset      (Reset),
        .ClearWrite (w_clearWrite),
        .ClearIndex (w_clearIndex),
        .Ready      (w_ready)
    );

    assign w_zeroHit     = (ZERO_REG != 0) && (bus.WriteAddress == '0);
    assign w_writeAccept = bus.WriteEnable && w_ready && !w_zeroHit;

    // The sweep owns the array until Ready; the index MSB never sets while sweeping.
    always_ff @(posedge Clock) begin
        if (w_clearWrite && !w_clearIndex[ADDR_WIDTH]) begin
            r_registers[w_clearIndex[ADDR_WIDTH-1:0]] <= '0;
        end else if (w_writeAccept && !Reset) begin
            r_registers[bus.WriteAddress] <= bus.WriteData;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_writeDropped <= 1'b0;
        end else begin
            r_writeDropped <= bus.WriteEnable && !w_writeAccept;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] w_addr;
        assign w_addr = bus.ReadAddress[p*ADDR_WIDTH +: ADDR_WIDTH];

        assign bus.ReadData[p*DATA_WIDTH +: DATA_WIDTH] =
            !w_ready                                                   ? '0 :
            ((ZERO_REG != 0) && (w_addr == '0))                        ? '0 :
            ((BYPASS != 0) && w_writeAccept && (bus.WriteAddress == w_addr))
                                                                       ? bus.WriteData :
                                                                         r_registers[w_addr];
    end

    assign bus.Ready        = w_ready;
    assign bus.WriteDropped = r_writeDropped;

endmodule : regfile_multiport

`default_nettype wire

// File: tb/tb_regfile_multiport.sv
// ============================================================================
// Module   : tb_regfile_multiport
// Brief    : Scoreboard bench for regfile_multiport with default parameters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_multiport;

    localparam int DW = 16;
    localparam int AW = 6;

    logic Clock = 1'b0;
    logic Reset;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        string         tag;
        int            port;
        logic [DW-1:0] value;
    } sb_entry_t;

    sb_entry_t sbQueue[$];

    regfile_multiport_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(2)) rfBus ();

    regfile_multiport #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_READ   (2),
        .BYPASS     (1),
        .ZERO_REG   (1)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (rfBus.slave)
    );

    always #5 Clock = ~Clock;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic expectRead(input string tag, input logic [DW-1:0] valA, input logic [DW-1:0] valB);
        sb_entry_t e;
        e.tag = {tag, "/A"}; e.port = 0; e.value = valA;
        sbQueue.push_back(e);
        e.tag = {tag, "/B"}; e.port = 1; e.value = valB;
        sbQueue.push_back(e);
    endtask

    task automatic sampleReads();
        sb_entry_t e;
        while (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkValue(e.tag, 32'(rfBus.ReadData[e.port*DW +: DW]), 32'(e.value));
        end
    endtask

    // Drive one cycle just after a posedge, compare reads at the negedge, then cross the next posedge.
    task automatic driveCycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        rfBus.WriteEnable  = we;
        rfBus.WriteAddress = wa;
        rfBus.WriteData    = wd;
        rfBus.ReadAddress  = {rb, ra};
        #4;
        sampleReads();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset              = 1'b1;
        rfBus.WriteEnable  = 1'b0;
        rfBus.WriteAddress = '0;
        rfBus.WriteData    = '0;
        rfBus.ReadAddress  = '0;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        checkValue("rst_ready", 32'(rfBus.Ready), 32'd0);
        checkValue("rst_dropped", 32'(rfBus.WriteDropped), 32'd0);
        expectRead("rst_read", 16'h0000, 16'h0000);
        driveCycle(1'b0, 6'd0, 16'h0000, 6'd5, 6'd9);
        Reset = 1'b0;

        // Scenario 1: sweep length and cleared contents
        for (int c = 1; c <= 64; c++) begin
            driveCycle(1'b0, 6'd0, 16'h0000, 6'd0, 6'd0);
            checkValue($sformatf("sweep_ready_%0d", c), 32'(rfBus.Ready), 32'(c == 64));
        end
        for (int a = 0; a < 64; a++) begin
            expectRead($sformatf("clr_%0d", a), 16'h0000, 16'h0000);
            driveCycle(1'b0, 6'd0, 16'h0000, AW'(a), AW'(63 - a));
        end

        // Scenario 2: plain writes then reads
        expectRead("s2_w1", 16'h0000, 16'h0000);
        driveCycle(1'b1, 6'd1, 16'h3D3A, 6'd0, 6'd0);
        expectRead("s2_w6", 16'h0000, 16'h0000);
        driveCycle(1'b1, 6'd6, 16'h000A, 6'd0, 6'd0);
        checkValue("s2_nodrop", 32'(rfBus.WriteDropped), 32'd0);
        expectRead("s2_read", 16'h3D3A, 16'h000A);
        driveCycle(1'b0, 6'd0, 16'h0000, 6'd1, 6'd6);

        // Scenario 3: bypass on one port, old value on the other
        expectRead("s3_w4", 16'h0000, 16'h0000);
        driveCycle(1'b1, 6'd4, 16'h4444, 6'd0, 6'd0);
        expectRead("s3_bypass", 16'hBEEF, 16'h4444);
        driveCycle(1'b1, 6'd5, 16'hBEEF, 6'd5, 6'd4);
        expectRead("s3_after", 16'hBEEF, 16'h4444);
        driveCycle(1'b0, 6'd0, 16'h0000, 6'd5, 6'd4);

        // Scenario 4: write to the zero register is dropped
        expectRead("s4_same", 16'h0000, 16'hBEEF);
        driveCycle(1'b1, 6'd0, 16'hFFFF, 6'd0, 6'd5);
        checkValue("s4_drop_pulse", 32'(rfBus.WriteDropped), 32'd1);
        expectRead("s4_after", 16'h0000, 16'h3D3A);
        driveCycle(1'b0, 6'd0, 16'h0000, 6'd0, 6'd1);
        checkValue("s4_drop_clear", 32'(rfBus.WriteDropped), 32'd0);

        // Scenarios 5/6: reset from READY, dropped write mid-sweep, sweep restart
        expectRead("s6_w7", 16'h0000, 16'h0000);
        driveCycle(1'b1, 6'd7, 16'h1234, 6'd0, 6'd0);
        expectRead("s6_w50", 16'h0000, 16'h0000);
        driveCycle(1'b1, 6'd50, 16'h5555, 6'd0, 6'd0);
        expectRead("s6_hold", 16'h1234, 16'h5555);
        driveCycle(1'b0, 6'd0, 16'h0000, 6'd7, 6'd50);
        Reset = 1'b1;
        expectRead("s6_rst_cycle", 16'h1234, 16'h5555);
        driveCycle(1'b0, 6'd0, 16'h0000, 6'd7, 6'd50);
        Reset = 1'b0;
        checkValue("s6_rst_ready", 32'(rfBus.Ready), 32'd0);
        for (int c = 1; c <= 30; c++) begin
            if (c == 30) Reset = 1'b1;
            expectRead($sformatf("s5_mask_%0d", c), 16'h0000, 16'h0000);
            driveCycle(c == 10, 6'd50, 16'hDEAD, 6'd7, 6'd50);
            if (c == 10) checkValue("s5_drop_pulse", 32'(rfBus.WriteDropped), 32'd1);
            if (c == 11) checkValue("s5_drop_clear", 32'(rfBus.WriteDropped), 32'd0);
        end
        Reset = 1'b0;
        checkValue("s6_restart_ready", 32'(rfBus.Ready), 32'd0);
        for (int c = 1; c <= 64; c++) begin
            driveCycle(1'b0, 6'd0, 16'h0000, 6'd0, 6'd0);
            checkValue($sformatf("s6_sweep_ready_%0d", c), 32'(rfBus.Ready), 32'(c == 64));
        end
        expectRead("s6_zeroed", 16'h0000, 16'h0000);
        driveCycle(1'b0, 6'd0, 16'h0000, 6'd7, 6'd50);
        expectRead("s6_w9", 16'h0000, 16'h0000);
        driveCycle(1'b1, 6'd9, 16'h5A5A, 6'd0, 6'd0);
        expectRead("s6_post", 16'h5A5A, 16'h0000);
        driveCycle(1'b0, 6'd0, 16'h0000, 6'd9, 6'd7);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule : tb_regfile_multiport

`default_nettype wire
